// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the instruction-memory responder.
//   imem_state_t  : responder FSM states
//   CNT_W         : latency counter width (supports LATENCY 1..15)
//   addr_in_range : byte-address window check, done on wide operands so
//                   base + size never wraps at the top of the address space
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_t;

   localparam int CNT_W = 4;

   // Callers zero-extend their AWIDTH-bit addresses; 64 bits leaves headroom
   // above AWIDTH+1 for any practical address width.
   function automatic logic addr_in_range(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] n_bytes);
      return (addr >= base) && (addr < (base + n_bytes));
   endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x DWIDTH instruction storage.
//   clk, rst          : clock, async active-low reset (read register only)
//   wr_en/wr_idx/
//   wr_lane/wr_byte   : byte write into lane wr_lane of word wr_idx
//   rd_en/rd_idx      : synchronous word read, captured into rd_data
//   rd_data           : registered read word; returns the pre-write value
//                       when a write hits the same word on the same edge
module imem_array #(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [1:0]        wr_lane,
   input  logic [7:0]        wr_byte,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DWIDTH-1:0] rd_data
);

   logic [DWIDTH-1:0] mem [DEPTH];

   // Storage is deliberately not reset; the program image is preloaded.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx][{wr_lane, 3'b000} +: 8] <= wr_byte;
      end
   end

   // Non-blocking read of mem on the same edge as a write yields old data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: serves fetch-stage PC requests from a preloaded
// instruction memory with a fixed LATENCY, flagging bad addresses.
//   clk, rst                       : clock, async active-low reset
//   req_valid/req_ready/req_addr   : fetch request channel
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_err                        : response channel (data 0 when err)
//   ld_en/ld_addr/ld_data          : byte-wide program load port
//
// state | meaning
// IDLE  | ready for a request; accept snapshots the word and error flag
// WAIT  | counting down the remaining latency
// RESP  | response presented, held until rsp_ready
module imem_responder
   import imem_pkg::*;
#(
   parameter int                DWIDTH   = 32,
   parameter int                AWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
   parameter int                DEPTH    = 1024,
   parameter int                LATENCY  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AWIDTH-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              ld_en,
   input  logic [AWIDTH-1:0] ld_addr,
   input  logic [7:0]        ld_data
);

   localparam int          IDX_W  = $clog2(DEPTH);
   localparam logic [63:0] BASE_W = 64'(BASEADDR);
   localparam logic [63:0] SPAN_W = 64'(DEPTH) * 64'd4;

   imem_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q;
   logic              req_fire;
   logic              req_err;
   logic              ld_hit;
   logic [IDX_W-1:0]  req_idx;
   logic [IDX_W-1:0]  ld_idx;
   logic [DWIDTH-1:0] rd_data;

   assign req_fire = req_valid && (state_q == IDLE);
   assign req_err  = (req_addr[1:0] != 2'b00) ||
                     !addr_in_range(64'(req_addr), BASE_W, SPAN_W);
   assign ld_hit   = ld_en && addr_in_range(64'(ld_addr), BASE_W, SPAN_W);
   assign req_idx  = IDX_W'((req_addr - BASEADDR) >> 2);
   assign ld_idx   = IDX_W'((ld_addr - BASEADDR) >> 2);

   imem_array #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ld_hit),
      .wr_idx  (ld_idx),
      .wr_lane (ld_addr[1:0]),
      .wr_byte (ld_data),
      .rd_en   (req_fire && !req_err),
      .rd_idx  (req_idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (req_fire) begin
            err_q <= req_err;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   // A flagged request never enables the read, so mask the stale word.
   assign rsp_data  = err_q ? '0 : rd_data;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

   localparam int          LAT   = 2;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h01000000;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [7:0]  ld_data;

   imem_responder #(
      .DWIDTH   (32),
      .AWIDTH   (32),
      .BASEADDR (BASE),
      .DEPTH    (DEPTH),
      .LATENCY  (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mdl [DEPTH];
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic logic in_win(input logic [31:0] a);
      return ({1'b0, a} >= {1'b0, BASE}) &&
             ({1'b0, a} < ({1'b0, BASE} + 33'(4 * DEPTH)));
   endfunction

   function automatic exp_t expect_for(input logic [31:0] a);
      exp_t e;
      e.err  = (a[1:0] != 2'b00) || !in_win(a);
      e.data = e.err ? 32'h0 : mdl[int'((a - BASE) >> 2)];
      return e;
   endfunction

   task automatic load_byte(input logic [31:0] a, input logic [7:0] b);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = b;
      if (in_win(a)) mdl[int'((a - BASE) >> 2)][8*a[1:0] +: 8] = b;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic issue_req(input logic [31:0] a, output int hs, output bit ok);
      int n = 0;
      req_addr  = a;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      ok = req_ready;
      hs = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int rc, output bit ok);
      int n = 0;
      while (!rsp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      ok = rsp_valid;
      rc = cyc;
   endtask

   task automatic test_reset(input string tag);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      n_tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
          rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_%s got rdy=%b vld=%b data=%h err=%b exp rdy=1 vld=0 data=0 err=0",
                  tag, req_ready, rsp_valid, rsp_data, rsp_err);
      end
   endtask

   task automatic test_load_program();
      load_byte(BASE + 0, 8'h13); load_byte(BASE + 1, 8'h00);
      load_byte(BASE + 2, 8'h50); load_byte(BASE + 3, 8'h00);
      load_byte(BASE + 4, 8'h93); load_byte(BASE + 5, 8'h00);
      load_byte(BASE + 6, 8'h10); load_byte(BASE + 7, 8'h00);
      load_byte(BASE + 32'h0FFC, 8'hEF); load_byte(BASE + 32'h0FFD, 8'hBE);
      load_byte(BASE + 32'h0FFE, 8'hAD); load_byte(BASE + 32'h0FFF, 8'hDE);
      // out-of-range writes that would alias word 0 / the last word if unchecked
      load_byte(BASE + 32'h1000, 8'hFF);
      load_byte(BASE - 32'h1,    8'hFF);
   endtask

   task automatic test_basic_fetch();
      int hs, rc; bit ok, ok2; exp_t e;
      exp_q.push_back(expect_for(BASE));
      issue_req(BASE, hs, ok);
      wait_rsp(rc, ok2);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || !ok2) begin
         n_fail++;
         $display("FAIL basic_timeout got acc=%b rsp=%b exp 1 1", ok, ok2);
      end
      n_tests++;
      if (rc - hs !== LAT) begin
         n_fail++;
         $display("FAIL basic_latency got %0d exp %0d", rc - hs, LAT);
      end
      n_tests++;
      if (rsp_data !== 32'h00500013 || rsp_data !== e.data || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_data got %h/%b exp 00500013/0", rsp_data, rsp_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_streaming();
      int hs_a, hs_b, rc; bit ok, ok2; exp_t e;
      exp_q.push_back(expect_for(BASE));
      exp_q.push_back(expect_for(BASE + 4));
      issue_req(BASE, hs_a, ok);
      wait_rsp(rc, ok2);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok2 || rsp_data !== e.data || rsp_err !== e.err) begin
         n_fail++;
         $display("FAIL stream_a got %h/%b exp %h/%b", rsp_data, rsp_err, e.data, e.err);
      end
      @(posedge clk); #1;
      issue_req(BASE + 4, hs_b, ok);
      wait_rsp(rc, ok2);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok2 || rsp_data !== e.data || rsp_err !== e.err) begin
         n_fail++;
         $display("FAIL stream_b got %h/%b exp %h/%b", rsp_data, rsp_err, e.data, e.err);
      end
      n_tests++;
      if (hs_b - hs_a !== LAT + 1) begin
         n_fail++;
         $display("FAIL stream_spacing got %0d exp %0d", hs_b - hs_a, LAT + 1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_errors();
      logic [31:0] addrs [4] = '{32'h01000002, 32'h00FFFFFC, 32'h01001000, 32'h01000FFC};
      logic        errs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         int hs, rc; bit ok, ok2; exp_t e;
         exp_q.push_back(expect_for(addrs[i]));
         issue_req(addrs[i], hs, ok);
         wait_rsp(rc, ok2);
         e = exp_q.pop_front();
         n_tests++;
         if (!ok2 || rsp_err !== errs[i] || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL err_%h got %h/%b exp %h/%b", addrs[i], rsp_data, rsp_err, e.data, errs[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int hs, rc; bit ok, ok2; exp_t e;
      logic [1:0] lanes [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [7:0] vals  [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      rsp_ready = 1'b0;
      exp_q.push_back(expect_for(BASE + 4));
      // same-word write in the accept cycle must not be visible
      ld_en   = 1'b1;
      ld_addr = BASE + 4;
      ld_data = 8'h11;
      mdl[1][7:0] = 8'h11;
      issue_req(BASE + 4, hs, ok);
      ld_en = 1'b0;
      wait_rsp(rc, ok2);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok2 || rsp_data !== 32'h00100093 || rsp_data !== e.data) begin
         n_fail++;
         $display("FAIL bp_collision got %h exp 00100093", rsp_data);
      end
      for (int i = 0; i < 5; i++) begin
         load_byte(BASE + 4 + 32'(lanes[i]), vals[i]);
         n_tests++;
         if (rsp_data !== e.data || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d got %h vld=%b rdy=%b exp %h vld=1 rdy=0",
                     i, rsp_data, rsp_valid, req_ready, e.data);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", rsp_valid, req_ready);
      end
      exp_q.push_back(expect_for(BASE + 4));
      issue_req(BASE + 4, hs, ok);
      wait_rsp(rc, ok2);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok2 || rsp_data !== 32'h44336655 || rsp_data !== e.data) begin
         n_fail++;
         $display("FAIL bp_newdata got %h exp 44336655", rsp_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_wait();
      int hs, rc; bit ok, ok2, seen; exp_t e;
      seen = 1'b0;
      issue_req(BASE, hs, ok);
      rst = 1'b0;
      #1 if (rsp_valid) seen = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      @(negedge clk) rst = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstwait_abort got seen=%b rdy=%b exp seen=0 rdy=1", seen, req_ready);
      end
      exp_q.push_back(expect_for(BASE + 32'h0FFC));
      issue_req(BASE + 32'h0FFC, hs, ok);
      wait_rsp(rc, ok2);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok2 || rc - hs !== LAT || rsp_data !== 32'hDEADBEEF || rsp_data !== e.data || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rstwait_next got %h/%b lat=%0d exp deadbeef/0 lat=%0d",
                  rsp_data, rsp_err, rc - hs, LAT);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      rsp_ready = 1'b1;
      ld_en     = 1'b0;
      ld_addr   = 32'h0;
      ld_data   = 8'h0;
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      test_reset("init");
      test_load_program();
      test_basic_fetch();
      test_streaming();
      test_errors();
      test_backpressure();
      test_reset("mid");
      test_reset_wait();

      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
